// File: rtl/cpu_boot_ctl_if.sv
// ============================================================================
//  Module      : cpu_boot_ctl_if
//  Description : Bundle of host-side control, image word stream and CPU-side
//                boot outputs used by cpu_boot_ctl.
//                master : host / testbench side (drives start/stop/words)
//                slave  : cpu_boot_ctl (drives word_ready and CPU controls)
//  Signals     : host_start, host_stop, host_len[IMG_AW], host_cksum[16],
//                word_in[16], word_valid, word_ready,
//                cpu_rst[2] (bit0 = CPU rst[1] LOAD, bit1 = CPU rst[2] RUN),
//                cpu_par[16], boot_done, busy, running, err[2]
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_boot_ctl_if #(
    parameter int IMG_AW = 11
);
    logic              host_start;
    logic              host_stop;
    logic [IMG_AW-1:0] host_len;
    logic [15:0]       host_cksum;
    logic [15:0]       word_in;
    logic              word_valid;
    logic              word_ready;
    logic [1:0]        cpu_rst;
    logic [15:0]       cpu_par;
    logic              boot_done;
    logic              busy;
    logic              running;
    logic [1:0]        err;

    modport master (
        output host_start, host_stop, host_len, host_cksum, word_in, word_valid,
        input  word_ready, cpu_rst, cpu_par, boot_done, busy, running, err
    );

    modport slave (
        input  host_start, host_stop, host_len, host_cksum, word_in, word_valid,
        output word_ready, cpu_rst, cpu_par, boot_done, busy, running, err
    );
endinterface

`default_nettype wire

// File: rtl/cpu_boot_ctl.sv
// ============================================================================
//  Module      : cpu_boot_ctl
//  Description : Boot sequencer for the embedded stack CPU. Holds the CPU in
//                reset, streams an image of host_len words into code BRAM via
//                cpu_par while cpu_rst=01, pulses boot_done to re-home the PC
//                and releases the CPU into RUN (cpu_rst=11).
//  Ports       : clk, rst (async, active high)
//                bus (cpu_boot_ctl_if.slave): host_start/host_stop/host_len/
//                host_cksum, word_in/word_valid/word_ready, cpu_rst, cpu_par,
//                boot_done, busy, running, err
//  Options     : BOOT_CKSUM_EN - when defined, a 16-bit wrapping sum of the
//                accepted words is checked against host_cksum before RUN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_boot_ctl #(
    parameter int IMG_AW = 11
) (
    input  wire logic     clk,
    input  wire logic     rst,
    cpu_boot_ctl_if.slave bus
);

    localparam logic [IMG_AW-1:0] C_ONE  = {{(IMG_AW-1){1'b0}}, 1'b1};
    localparam logic [IMG_AW-1:0] C_ZERO = '0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRIME = 3'd1,
        ST_LOAD  = 3'd2,
        ST_DONE  = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    state_t            r_state;
    logic [IMG_AW-1:0] r_len;
    logic [IMG_AW-1:0] r_rem;          // words still to be accepted in LOAD
    logic              r_word_ready;
    logic [1:0]        r_cpu_rst;
    logic [15:0]       r_cpu_par;
    logic              r_boot_done;
    logic              r_busy;
    logic              r_running;
    logic [1:0]        r_err;

    logic              w_accept;
    logic              w_cksum_ok;

    // host_stop overrides everything, so a word offered in a stop cycle is
    // not consumed.
    assign w_accept = bus.word_valid & r_word_ready & ~bus.host_stop;

`ifdef BOOT_CKSUM_EN
    logic [15:0] r_cksum;
    logic [15:0] r_sum;

    assign w_cksum_ok = (r_sum == r_cksum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum   <= 16'h0000;
            r_cksum <= 16'h0000;
        end else if (!bus.host_stop && (r_state == ST_IDLE) && bus.host_start) begin
            r_sum   <= 16'h0000;
            r_cksum <= bus.host_cksum;
        end else if (w_accept) begin
            r_sum   <= r_sum + bus.word_in;
        end
    end
`else
    logic w_unused_cksum;

    assign w_cksum_ok     = 1'b1;
    assign w_unused_cksum = ^bus.host_cksum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_len        <= C_ZERO;
            r_rem        <= C_ZERO;
            r_word_ready <= 1'b0;
            r_cpu_rst    <= 2'b00;
            r_cpu_par    <= 16'h0000;
            r_boot_done  <= 1'b0;
            r_busy       <= 1'b0;
            r_running    <= 1'b0;
            r_err        <= 2'b00;
        end else if (bus.host_stop) begin
            r_state      <= ST_IDLE;
            r_word_ready <= 1'b0;
            r_cpu_rst    <= 2'b00;
            r_boot_done  <= 1'b0;
            r_busy       <= 1'b0;
            r_running    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.host_start) begin
                        r_len        <= bus.host_len;
                        r_err        <= 2'b00;
                        r_word_ready <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= ST_PRIME;
                    end
                end

                ST_PRIME: begin
                    // Source may stall here for as long as it likes.
                    if (w_accept) begin
                        r_cpu_par    <= bus.word_in;
                        // len=0 wraps to all-ones, i.e. a full 2^IMG_AW image.
                        r_rem        <= r_len - C_ONE;
                        r_word_ready <= (r_len != C_ONE);
                        r_cpu_rst    <= 2'b01;
                        r_state      <= ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (r_rem == C_ZERO) begin
                        // cpu_par already holds the last word.
                        r_boot_done <= 1'b1;
                        r_state     <= ST_DONE;
                    end else if (w_accept) begin
                        r_cpu_par    <= bus.word_in;
                        r_rem        <= r_rem - C_ONE;
                        r_word_ready <= (r_rem != C_ONE);
                    end else begin
                        // The CPU writes every cycle, so a gap would corrupt
                        // the image: abort and keep the CPU in reset.
                        r_err[0]     <= 1'b1;
                        r_cpu_rst    <= 2'b00;
                        r_word_ready <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end

                ST_DONE: begin
                    r_boot_done <= 1'b0;
                    r_busy      <= 1'b0;
                    if (w_cksum_ok) begin
                        r_cpu_rst <= 2'b11;
                        r_running <= 1'b1;
                        r_state   <= ST_RUN;
                    end else begin
                        r_err[1]  <= 1'b1;
                        r_cpu_rst <= 2'b00;
                        r_state   <= ST_IDLE;
                    end
                end

                ST_RUN: begin
                    // Only host_stop or rst leaves RUN.
                end

                default: begin
                    r_state      <= ST_IDLE;
                    r_cpu_rst    <= 2'b00;
                    r_word_ready <= 1'b0;
                    r_boot_done  <= 1'b0;
                    r_busy       <= 1'b0;
                    r_running    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.word_ready = r_word_ready;
    assign bus.cpu_rst    = r_cpu_rst;
    assign bus.cpu_par    = r_cpu_par;
    assign bus.boot_done  = r_boot_done;
    assign bus.busy       = r_busy;
    assign bus.running    = r_running;
    assign bus.err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cpu_boot_ctl.sv
// ============================================================================
//  Module      : tb_cpu_boot_ctl
//  Description : Self-checking bench for cpu_boot_ctl. A driver issues boot
//                requests and pushes the words the CPU should see into a
//                scoreboard queue; a monitor pops and compares every LOAD
//                cycle and checks the DONE/RUN/abort sequencing.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_boot_ctl;

    localparam int AW   = 11;
    localparam int FULL = 1 << AW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpu_boot_ctl_if #(.IMG_AW(AW)) bus ();
    cpu_boot_ctl #(.IMG_AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] img[$];
    logic [15:0] exp_q[$];
    int          exp_len;
    logic [1:0]  exp_final;
    bit          exp_abort;
    logic [1:0]  last_exp_err = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] img_sum(input int n);
        logic [15:0] s;
        s = 16'h0000;
        for (int i = 0; i < n; i++) s = s + img[i];
        return s;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        m_in_load;
    logic        m_prev_load = 1'b0;
    logic        m_prev_done = 1'b0;
    int          m_load_run  = 0;
    logic [15:0] m_exp_word;

    always @(negedge clk) begin
        if (rst) begin
            m_prev_load = 1'b0;
            m_prev_done = 1'b0;
            m_load_run  = 0;
            exp_q.delete();
        end else begin
            m_in_load = (bus.cpu_rst == 2'b01) && !bus.boot_done;
            check("cpu_rst_never_10", {31'd0, bus.cpu_rst != 2'b10}, 32'd1);
            if (m_in_load) begin
                m_load_run++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL load_extra_word: got cpu_par %0h with no word expected at %0t",
                             bus.cpu_par, $time);
                end else begin
                    m_exp_word = exp_q.pop_front();
                    check("cpu_par", bus.cpu_par, m_exp_word);
                end
            end
            if (bus.boot_done) begin
                check("done_follows_load", m_prev_load, 1);
                check("load_cycles", m_load_run, exp_len);
                check("all_words_presented", exp_q.size(), 0);
                check("done_cpu_rst", bus.cpu_rst, 2'b01);
            end
            if (m_prev_done) begin
                check("done_one_cycle", bus.boot_done, 0);
                check("post_done_cpu_rst", bus.cpu_rst, exp_final);
            end
            if (m_prev_load && !m_in_load && !bus.boot_done) begin
                check("abort_expected", exp_abort, 1);
                check("abort_cpu_rst", bus.cpu_rst, 2'b00);
                check("abort_words_presented", exp_q.size(), 0);
            end
            if (!m_in_load) m_load_run = 0;
            m_prev_load = m_in_load;
            m_prev_done = bus.boot_done;
        end
    end

    // ---------------- driver ----------------
    // drop>0: withhold word[drop] once (underrun). stop_at>=0: host_stop in
    // LOAD cycle stop_at. rst_in_done: async reset while boot_done is high.
    task automatic do_load(input logic [AW-1:0] len_f, input logic [15:0] cks,
                           input int drop, input int stop_at,
                           input bit rst_in_done, input bit stall);
        int         eff, n_show, idx, lc;
        bit         dropped, stop_now, timed_out, ok;
        logic [1:0] exp_err;
        eff = (len_f == '0) ? FULL : int'(len_f);
        ok  = 1'b1;
`ifdef BOOT_CKSUM_EN
        ok  = (img_sum(eff) == cks);
`endif
        if (drop > 0) begin
            n_show = drop;        exp_err = 2'b01;
        end else if (stop_at >= 0) begin
            n_show = stop_at + 1; exp_err = 2'b00;
        end else begin
            n_show = eff;         exp_err = ok ? 2'b00 : 2'b10;
        end
        exp_q.delete();
        for (int i = 0; i < n_show; i++) exp_q.push_back(img[i]);
        exp_len      = eff;
        exp_abort    = (drop > 0) || (stop_at >= 0);
        exp_final    = ok ? 2'b11 : 2'b00;
        last_exp_err = rst_in_done ? 2'b00 : exp_err;

        @(posedge clk); #1;
        bus.host_start = 1'b1;
        bus.host_len   = len_f;
        bus.host_cksum = cks;
        idx = 0; lc = 0; dropped = 1'b0; timed_out = 1'b1;
        for (int c = 0; c < eff + 200; c++) begin
            @(posedge clk); #1;
            bus.host_start = 1'b0;
            stop_now       = (stop_at >= 0) && (lc == stop_at);
            bus.host_stop  = stop_now;
            if (drop > 0 && idx == drop && !dropped) begin
                bus.word_valid = 1'b0;
                dropped        = 1'b1;
            end else if (stall && idx == 0 && $urandom_range(0, 2) == 0) begin
                bus.word_valid = 1'b0;
            end else if (idx < img.size()) begin
                bus.word_valid = 1'b1;
                bus.word_in    = img[idx];
            end else begin
                bus.word_valid = 1'b0;
            end
            @(negedge clk);
            if (c == 0) begin
                check("prime_busy", bus.busy, 1);
                check("prime_word_ready", bus.word_ready, 1);
                check("prime_cpu_rst", bus.cpu_rst, 2'b00);
                check("prime_err_cleared", bus.err, 2'b00);
            end
            if (bus.word_valid && bus.word_ready && !stop_now) idx++;
            if (bus.cpu_rst == 2'b01 && !bus.boot_done) lc++;
            if (rst_in_done && bus.boot_done) begin
                #2 rst = 1'b1;
                #1;
                check("async_rst_boot_done", bus.boot_done, 0);
                check("async_rst_cpu_rst", bus.cpu_rst, 2'b00);
                check("async_rst_busy", bus.busy, 0);
                @(negedge clk);
                @(posedge clk);
                #2 rst = 1'b0;
                timed_out = 1'b0;
                break;
            end
            if (bus.running || (idx > 0 && !bus.busy)) begin
                timed_out = 1'b0;
                break;
            end
        end
        bus.host_stop  = 1'b0;
        bus.word_valid = 1'b0;

        if (timed_out) begin
            n_tests++;
            n_fail++;
            $display("FAIL load_timeout: got no completion within %0d cycles, required RUN/IDLE", eff + 200);
        end else if (rst_in_done) begin
            check("post_rst_cpu_par", bus.cpu_par, 16'h0000);
            check("post_rst_running", bus.running, 0);
            check("post_rst_word_ready", bus.word_ready, 0);
            check("post_rst_err", bus.err, 2'b00);
        end else begin
            check("words_accepted", idx, exp_abort ? n_show : eff);
            check("final_running", bus.running, !exp_abort && ok);
            check("final_cpu_rst", bus.cpu_rst, (!exp_abort && ok) ? 2'b11 : 2'b00);
            check("final_err", bus.err, exp_err);
            check("final_word_ready", bus.word_ready, 0);
            check("final_busy", bus.busy, 0);
        end
    endtask

    task automatic stop_to_idle();
        @(posedge clk); #1 bus.host_stop = 1'b1;
        @(posedge clk); #1 bus.host_stop = 1'b0;
        @(negedge clk);
        check("stop_cpu_rst", bus.cpu_rst, 2'b00);
        check("stop_running", bus.running, 0);
        check("stop_err_unchanged", bus.err, last_exp_err);
    endtask

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(16'($urandom));
    endtask

    // ---------------- main sequence ----------------
    int          r_len_i, r_drop;
    logic [15:0] r_cks;

    initial begin
        bus.host_start = 1'b0;
        bus.host_stop  = 1'b0;
        bus.host_len   = '0;
        bus.host_cksum = 16'h0000;
        bus.word_in    = 16'h0000;
        bus.word_valid = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_cpu_rst", bus.cpu_rst, 2'b00);
        check("rst_cpu_par", bus.cpu_par, 16'h0000);
        check("rst_boot_done", bus.boot_done, 0);
        check("rst_word_ready", bus.word_ready, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_running", bus.running, 0);
        check("rst_err", bus.err, 2'b00);
        @(posedge clk); #1 rst = 1'b0;

        // Four-word directed image, back-to-back.
        img = '{16'h8000, 16'h0005, 16'hA001, 16'h1234, 16'hDEAD, 16'hBEEF};
        do_load(AW'(4), img_sum(4), 0, -1, 1'b0, 1'b0);

        // host_start is ignored while running.
        @(posedge clk); #1 bus.host_start = 1'b1; bus.host_len = AW'(2);
        @(posedge clk); #1 bus.host_start = 1'b0;
        @(negedge clk);
        check("run_ignores_start_running", bus.running, 1);
        check("run_ignores_start_cpu_rst", bus.cpu_rst, 2'b11);
        check("run_ignores_start_busy", bus.busy, 0);
        stop_to_idle();

        // len=0: full 2^AW image, stream offers more words than that.
        fill_random(FULL + 20);
        do_load('0, img_sum(FULL), 0, -1, 1'b0, 1'b0);
        stop_to_idle();

        // Underrun at word 5 of 8.
        fill_random(12);
        do_load(AW'(8), img_sum(8), 5, -1, 1'b0, 1'b1);

        // Simultaneous start+stop in IDLE: stop wins, err is not cleared.
        @(posedge clk); #1 bus.host_start = 1'b1; bus.host_stop = 1'b1; bus.host_len = AW'(8);
        @(posedge clk); #1 bus.host_start = 1'b0; bus.host_stop = 1'b0;
        @(negedge clk);
        check("start_stop_busy", bus.busy, 0);
        check("start_stop_word_ready", bus.word_ready, 0);
        check("start_stop_err", bus.err, 2'b01);

        // Clean reload clears err and reaches RUN.
        do_load(AW'(8), img_sum(8), 0, -1, 1'b0, 1'b1);
        stop_to_idle();

        // Checksum cases (mismatch only matters with the checker enabled).
        img = '{16'd1, 16'd2, 16'd3, 16'd9};
        do_load(AW'(3), 16'd6, 0, -1, 1'b0, 1'b0);
        stop_to_idle();
        do_load(AW'(3), 16'd7, 0, -1, 1'b0, 1'b0);
        stop_to_idle();

        // host_stop during LOAD cycle 2.
        fill_random(12);
        do_load(AW'(8), img_sum(8), 0, 2, 1'b0, 1'b0);
        stop_to_idle();

        // Async reset while boot_done is high.
        fill_random(6);
        do_load(AW'(3), img_sum(3), 0, -1, 1'b1, 1'b0);

        // Randomised loads.
        for (int t = 0; t < 10; t++) begin
            r_len_i = $urandom_range(1, 24);
            fill_random(r_len_i + 4);
            r_drop = (r_len_i > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, r_len_i - 1) : 0;
            r_cks  = img_sum(r_len_i);
            if ($urandom_range(0, 1) == 1) r_cks = r_cks ^ 16'($urandom_range(1, 65535));
            do_load(AW'(r_len_i), r_cks, r_drop, -1, 1'b0, 1'b1);
            stop_to_idle();
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
